// File: rtl/reg_readback_tx_pkg.sv
// Shared definitions for the register readback transmitter.
// Holds state encoding, frame length derivation and SPI idle levels.
package reg_readback_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_SHIFT  = 3'd2,
        S_HOLD   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // SPI mode-0 idle levels
    localparam logic SCK_IDLE = 1'b0;
    localparam logic CS_IDLE  = 1'b1;

    function automatic int frame_len(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/reg_readback_tx_serial_shift_reg.sv
// Parallel-load, shift-left register with the MSB as serial output.
// Ports: clk, rst (sync, active high), load/din, shift, sout.
module serial_shift_reg #(
    parameter int Width = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] din,
    input  logic             shift,
    output logic             sout
);

    logic [Width-1:0] q;

    // Load wins over shift; zeros enter at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[Width-2:0], 1'b0};
        end
    end

    assign sout = q[Width-1];

endmodule

// File: rtl/reg_readback_tx.sv
// Serial readback transmitter: snapshots one register and sends
// {addr, data} MSB first over a self-generated SPI mode-0 link.
// Ports: CLK, RST (sync, active high), Start, Addr, RegData in;
//        CS_N, SCK, SDO, Busy, Done out.
module reg_readback_tx
    import reg_readback_tx_pkg::*;
#(
    parameter int BitWidth  = 8,
    parameter int NumRegs   = 8,
    parameter int AddrWidth = 3,
    parameter int ClkDiv    = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Start,
    input  logic [AddrWidth-1:0]          Addr,
    input  logic [NumRegs*BitWidth-1:0]   RegData,
    output logic                          CS_N,
    output logic                          SCK,
    output logic                          SDO,
    output logic                          Busy,
    output logic                          Done
);

    localparam int FrameLen = frame_len(AddrWidth, BitWidth);
    localparam int DivW     = $clog2(ClkDiv) + 1;
    localparam int BitW     = $clog2(FrameLen) + 1;

    localparam logic [DivW-1:0] DivMax = DivW'(ClkDiv - 1);
    localparam logic [DivW-1:0] DivOne = DivW'(1);
    localparam logic [BitW-1:0] BitMax = BitW'(FrameLen - 1);
    localparam logic [BitW-1:0] BitOne = BitW'(1);

    state_t              state_q, state_d;
    logic [DivW-1:0]     div_q, div_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic                sck_q, sck_d;
    logic                load;
    logic                shift_en;
    logic                div_last;
    logic                sout;
    logic [BitWidth-1:0] sel_data;
    logic [FrameLen-1:0] frame;

    // Out-of-range addresses leave the data field at zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (int'(Addr) == i) begin
                sel_data = RegData[i*BitWidth +: BitWidth];
            end
        end
    end

    assign frame    = {Addr, sel_data};
    assign div_last = (div_q == DivMax);

    serial_shift_reg #(
        .Width (FrameLen)
    ) u_shift (
        .clk   (CLK),
        .rst   (RST),
        .load  (load),
        .din   (frame),
        .shift (shift_en),
        .sout  (sout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sck_q   <= SCK_IDLE;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sck_d    = sck_q;
        load     = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    load    = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    sck_d   = SCK_IDLE;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + DivOne;
                end
            end
            S_SHIFT: begin
                if (div_last) begin
                    div_d = '0;
                    if (sck_q == SCK_IDLE) begin
                        sck_d = ~SCK_IDLE;
                    end else begin
                        // Falling edge: present the next bit.
                        sck_d    = SCK_IDLE;
                        shift_en = 1'b1;
                        if (bit_q == BitMax) begin
                            state_d = S_HOLD;
                        end else begin
                            bit_d = bit_q + BitOne;
                        end
                    end
                end else begin
                    div_d = div_q + DivOne;
                end
            end
            S_HOLD: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_FINISH;
                end else begin
                    div_d = div_q + DivOne;
                end
            end
            S_FINISH: begin
                div_d   = '0;
                bit_d   = '0;
                sck_d   = SCK_IDLE;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        CS_N = CS_IDLE;
        SCK  = SCK_IDLE;
        SDO  = 1'b0;
        Busy = 1'b0;
        Done = 1'b0;
        unique case (state_q)
            S_SETUP, S_HOLD: begin
                CS_N = ~CS_IDLE;
                SDO  = sout;
                Busy = 1'b1;
            end
            S_SHIFT: begin
                CS_N = ~CS_IDLE;
                SCK  = sck_q;
                SDO  = sout;
                Busy = 1'b1;
            end
            S_FINISH: begin
                Done = 1'b1;
            end
            default: begin
                CS_N = CS_IDLE;
            end
        endcase
    end

endmodule

// File: doc/reg_readback_tx.md
Name: reg_readback_tx

Overview:
- Serial readback transmitter for the PWM IO expander register file.
- The host-write path loads the N-bit configuration and duty registers; this block is the read direction.
- On a start request it snapshots one selected register and shifts an {address, data} frame out MSB-first on an SPI mode-0 style link (CS_N, SCK, SDO) that it generates itself.
- Sits between the register bank and the host-facing pins.

Parameters:
- BitWidth, 8, width of each register and of the data field in the frame.
- NumRegs, 8, number of registers presented on RegData.
- AddrWidth, 3, width of Addr and of the address field in the frame.
- ClkDiv, 4, CLK cycles per SCK half-period; must be at least 1.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- Start  input  1  request a readback; sampled only while idle.
- Addr  input  AddrWidth  register index, sampled with Start.
- RegData  input  NumRegs*BitWidth  flattened register bank; register i occupies bits [i*BitWidth +: BitWidth].
- CS_N  output  1  frame select, active low.
- SCK  output  1  serial clock, idles low.
- SDO  output  1  serial data, MSB first.
- Busy  output  1  high from the cycle after an accepted Start until Done.
- Done  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RST).
- Reset values: CS_N=1, SCK=0, SDO=0, Busy=0, Done=0, state=IDLE, all counters 0.
- Frame: FrameLen = AddrWidth+BitWidth bits; frame = {Addr, selected register}, sent MSB first. Default FrameLen=11.
- States: IDLE, SETUP, SHIFT, HOLD, FINISH.
- IDLE:
  - Start=1 on cycle 0 latches Addr and the addressed RegData slice into the shift register.
  - If Addr >= NumRegs, the data field is all zeros.
  - Enters SETUP at cycle 1.
- SETUP:
  - CS_N=0, SCK=0, SDO=frame MSB, Busy=1.
  - Lasts ClkDiv cycles, then enters SHIFT.
- SHIFT:
  - SCK rises after ClkDiv cycles and falls ClkDiv cycles later.
  - On each falling edge SDO advances to the next bit; SDO is stable across every rising edge.
  - After FrameLen full SCK periods, with SCK back low, enters HOLD.
- HOLD: CS_N=0, SCK=0 for ClkDiv cycles, then enters FINISH.
- FINISH:
  - Single cycle: CS_N=1, SDO=0, Busy=0, Done=1.
  - Next cycle is IDLE.
- Latency: Done is asserted at cycle 1+ClkDiv*(2*FrameLen+2). With defaults this is cycle 97.
- Snapshot: changes on RegData or Addr after cycle 0 have no effect on the frame in flight.
- Start handling:
  - Start while Busy=1, including during FINISH, is ignored and not queued.
  - Start on the cycle after Done, in IDLE, is accepted.
- Reset:
  - RST mid-frame forces the reset values on the next edge; Done is not pulsed and the partial frame is abandoned.
  - RST and Start in the same cycle: reset wins.
- Counters: the divide counter is sized ceil(log2(ClkDiv))+1 and the bit counter ceil(log2(FrameLen))+1. Neither wraps within a frame.

Decomposition:
- Shared package:
  - State encoding constants (IDLE..FINISH, 3 bits).
  - FrameLen derivation.
  - The SPI mode-0 idle levels (SCK_IDLE=0, CS_IDLE=1).
- One sub-module: serial_shift_reg.
  - Parameterised width.
  - Parallel load, shift-left on enable, MSB as serial out.
  - Synchronous active-high reset.
- The FSM, clock divider and bit counter stay in reg_readback_tx.

Test Plan:
- Reset values: hold RST=1 for 3 cycles -> CS_N=1, SCK=0, SDO=0, Busy=0, Done=0 on every cycle.
- Basic frame: register 5 = 0xA5, Start with Addr=5 -> sampling SDO on SCK rising edges gives 101_10100101; exactly 11 SCK pulses; Done pulses once at cycle 97; CS_N high again at cycle 97.
- Snapshot and busy: during the frame, change register 5 to 0x3C and pulse Start with Addr=2 at cycle 40 -> the transmitted frame is still 101_10100101 and no second frame follows.
- Reset mid-frame: assert RST at cycle 40 -> next cycle CS_N=1, SCK=0, Busy=0, and Done never pulses; a new Start afterwards sends a correct full frame.
- Back-to-back: Start at cycle 0 with Addr=0 (0xFF), then Start on the cycle after Done with Addr=7 (0x00) -> frames 000_11111111 and 111_00000000; the second Done pulses 97 cycles after the second Start.
- ClkDiv=1, NumRegs=6: Start with Addr=6 -> frame 110_00000000; Done at cycle 25.
